hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised D-stage hazard controller for the pipelined MIPS core. It takes the decoder's per-instruction `tuse_rs`/`tuse_rt`/`tnew`/`A3` fields and tracks every in-flight register writer in a shift-register scoreboard of configurable depth. From that scoreboard it produces the D-stage stall, the D-stage forwarding selects, and a mult/div busy window with configurable latencies. It sits between the decoder and the D/E pipeline register, replacing the fixed three-stage compare logic.

## Interface
- `STAGES`, 3: tracked stages after D (1=E, 2=M, 3=W, ...); ≥1
- `TW`, 3: width of tnew/tuse fields
- `MULT_CYC`, 5: busy cycles after a mult/multu issues
- `DIV_CYC`, 10: busy cycles after a div/divu issues
- `SW`, $clog2(STAGES+1): forwarding-select width

Ports:
- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-high
- `d_valid` in 1: D stage holds a real instruction
- `d_A1`, `d_A2` in 5: rs, rt of the D instruction
- `d_tuse_rs`, `d_tuse_rt` in TW: cycles until rs/rt are needed (6 = unused)
- `d_A3` in 5: destination register
- `d_regwrite` in 1: D instruction writes `d_A3`
- `d_tnew` in TW: decoder tnew (cycles from D until the result exists)
- `d_isdm` in 1: D instruction touches the mult/div unit
- `d_md_start` in 1: D instruction is mult/multu/div/divu
- `d_md_div` in 1: the start is a div/divu (selects DIV_CYC)
- `flush` in 1: exception/eret flush of all tracked stages
- `stall` out 1: freeze PC and F/D, bubble into E
- `fwd_rs_sel`, `fwd_rt_sel` out SW: 0 = register file, k = stage k result
- `md_busy` out 1: mult/div unit busy

## Operation
- Entry k (1..STAGES) holds `{valid, wr, a3, rem}`. `rem` is the number of cycles remaining until stage k holds the result.
- Issue: on a clock edge with `d_valid && !stall && !flush`, entry1 ← `{1, d_regwrite && d_A3!=0, d_A3, sat(d_tnew-1)}`. Otherwise entry1 ← bubble (all 0).
- Advance: every edge, entry k+1 ← entry k with `rem` decremented, saturating at 0. Entry STAGES is dropped.
- `flush`: all entries ← 0 on the edge. Takes priority over issue.
- A match for a source register `r` (with `r!=0`) is the lowest k where `valid && wr && a3==r`. Only the youngest match counts.
- rs hazard: the match exists and `rem_k > d_tuse_rs`. The rt hazard is the same check against `d_tuse_rt`.
- `fwd_*_sel` = k when the match has `rem_k==0`, else 0. The select is still 0 when the match is pending but not stalling; downstream forwarding covers that case.
- md hazard: `d_isdm && md_busy`.
- `stall` = `d_valid && !flush && (rs_haz || rt_haz || md_haz)`.
- Mult/div counter `mdc`: issue of `d_md_start` loads MULT_CYC or DIV_CYC. Otherwise `mdc` decrements while nonzero.
- `md_busy` = `mdc!=0`. `flush` does not touch `mdc`, because HI/LO keep computing.
- `reset` clears all entries and `mdc`. It has priority over `flush` and issue.

## Timing
- `stall` and `fwd_*_sel` are combinational from the D inputs and the registered scoreboard, valid in the same cycle.
- Scoreboard and `mdc` update on the rising edge only.
- Reset values: every entry 0, `mdc`=0, `stall`=0, `fwd_*_sel`=0, `md_busy`=0.
- lw (tnew 3) followed by a consumer with tuse 1: one stall cycle, then forward from sel 3 (W)? No. After the stall cycle the lw sits in M with rem 1, which satisfies tuse 1, so the consumer issues with sel 0 and forwarding happens downstream.
- Branch consumer (tuse 0) behind an ALU op (tnew 2): stall 1 cycle, then sel=2.
- mult issued at edge t: `md_busy`=1 for edges t..t+MULT_CYC-1 and drops after MULT_CYC cycles. An mfhi in D stalls for exactly those cycles.
- Stalled cycles insert bubbles. Entries downstream keep advancing, so a stall never freezes the scoreboard.

## Test plan
- Reset mid-operation: fill all entries and start a div, assert `reset` for 1 cycle → next cycle all selects 0, `stall`=0, `md_busy`=0.
- `addu $3,..` (tnew 2) then `beq $3,$3` (tuse 0) → `stall`=1 for 1 cycle, then `fwd_rs_sel`=`fwd_rt_sel`=2 with `stall`=0.
- `lw $5` then `addu $6,$5,$0` (tuse 1) → 1 stall cycle, then `fwd_rs_sel`=0 with no stall. With `sw $5` (tuse_rt 2) instead → 0 stalls.
- Two writers of `$7` in E and M, `jr $7` in D → match is the E entry; stall until its rem is 0, then sel=1. Also `$0` writers → never stall, sel 0.
- `div` (DIV_CYC=10) then `mflo` → `md_busy` high 10 cycles, `stall` high 10 cycles. A `flush` during this window leaves `md_busy` unchanged.
- `flush` with `lw $2` in E and a dependent instruction in D → `stall`=0 that cycle. Next cycle all entries are empty and `$2` readers are not stalled.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// D-stage hazard controller: a shift-register scoreboard of in-flight register writers
// that drives the D-stage stall, the forwarding selects and the mult/div busy window.
module hazard_scoreboard #(
  parameter int STAGES   = 3,
  parameter int TW       = 3,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int SW       = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [4:0]    d_A1,
  input  logic [4:0]    d_A2,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [4:0]    d_A3,
  input  logic          d_regwrite,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_isdm,
  input  logic          d_md_start,
  input  logic          d_md_div,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_rs_sel,
  output logic [SW-1:0] fwd_rt_sel,
  output logic          md_busy
);

  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  logic [STAGES:1] valid_q;
  logic [STAGES:1] wr_q;
  logic [4:0]      a3_q  [1:STAGES];
  logic [TW-1:0]   rem_q [1:STAGES];
  logic [CW-1:0]   mdc_q, mdc_d;

  logic          rsHit, rtHit;
  logic [SW-1:0] rsK, rtK;
  logic [TW-1:0] rsRem, rtRem;
  logic          rsHaz, rtHaz, mdHaz;
  logic          issue;
  logic [TW-1:0] remIssue;

  // Walking from the oldest entry down to E leaves the youngest match in place.
  always_comb begin
    rsHit = 1'b0;
    rtHit = 1'b0;
    rsK   = '0;
    rtK   = '0;
    rsRem = '0;
    rtRem = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (valid_q[k] && wr_q[k] && (a3_q[k] == d_A1) && (d_A1 != 5'd0)) begin
        rsHit = 1'b1;
        rsK   = SW'(k);
        rsRem = rem_q[k];
      end
      if (valid_q[k] && wr_q[k] && (a3_q[k] == d_A2) && (d_A2 != 5'd0)) begin
        rtHit = 1'b1;
        rtK   = SW'(k);
        rtRem = rem_q[k];
      end
    end
  end

  assign rsHaz      = rsHit && (rsRem > d_tuse_rs);
  assign rtHaz      = rtHit && (rtRem > d_tuse_rt);
  assign md_busy    = (mdc_q != '0);
  assign mdHaz      = d_isdm && md_busy;
  assign stall      = d_valid && !flush && (rsHaz || rtHaz || mdHaz);
  assign fwd_rs_sel = (rsHit && (rsRem == '0)) ? rsK : '0;
  assign fwd_rt_sel = (rtHit && (rtRem == '0)) ? rtK : '0;

  assign issue    = d_valid && !stall && !flush;
  assign remIssue = (d_tnew != '0) ? d_tnew - 1'b1 : '0;

  always_comb begin
    mdc_d = mdc_q;
    if (issue && d_md_start) begin
      mdc_d = d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (mdc_q != '0) begin
      mdc_d = mdc_q - 1'b1;
    end
  end

  // Flush empties the scoreboard but leaves the mult/div counter running.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        valid_q[k] <= 1'b0;
        wr_q[k]    <= 1'b0;
        a3_q[k]    <= 5'd0;
        rem_q[k]   <= '0;
      end
      mdc_q <= '0;
    end else begin
      if (flush) begin
        for (int k = 1; k <= STAGES; k++) begin
          valid_q[k] <= 1'b0;
          wr_q[k]    <= 1'b0;
          a3_q[k]    <= 5'd0;
          rem_q[k]   <= '0;
        end
      end else begin
        valid_q[1] <= issue;
        wr_q[1]    <= issue && d_regwrite && (d_A3 != 5'd0);
        a3_q[1]    <= issue ? d_A3 : 5'd0;
        rem_q[1]   <= issue ? remIssue : '0;
        for (int k = 2; k <= STAGES; k++) begin
          valid_q[k] <= valid_q[k-1];
          wr_q[k]    <= wr_q[k-1];
          a3_q[k]    <= a3_q[k-1];
          rem_q[k]   <= (rem_q[k-1] != '0) ? rem_q[k-1] - 1'b1 : '0;
        end
      end
      mdc_q <= mdc_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a history-based model.
module tb_hazard_scoreboard;

  localparam int STG = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_A1, d_A2, d_A3;
  logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_regwrite, d_isdm, d_md_start, d_md_div, flush;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic       md_busy;

  int errors = 0;
  int checks = 0;

  // Model: what was issued k edges ago, plus the cycle the mult/div unit frees up.
  int hv  [1:STG];
  int hwr [1:STG];
  int ha3 [1:STG];
  int htn [1:STG];
  int cyc = 0;
  int busyUntil = 0;
  int eStall, eRs, eRt, eBusy;

  hazard_scoreboard #(.STAGES(3), .TW(3), .MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_A1(d_A1), .d_A2(d_A2),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_A3(d_A3),
    .d_regwrite(d_regwrite), .d_tnew(d_tnew), .d_isdm(d_isdm),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .flush(flush),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  function automatic void lookup(input int r, input int tuse, output int haz, output int sel);
    haz = 0;
    sel = 0;
    if (r != 0) begin
      for (int k = 1; k <= STG; k++) begin
        if (hv[k] != 0 && hwr[k] != 0 && ha3[k] == r) begin
          int rem;
          rem = (htn[k] > k) ? htn[k] - k : 0;
          haz = (rem > tuse) ? 1 : 0;
          sel = (rem == 0) ? k : 0;
          break;
        end
      end
    end
  endfunction

  function automatic void computeModel();
    int rsH, rtH;
    lookup(int'(d_A1), int'(d_tuse_rs), rsH, eRs);
    lookup(int'(d_A2), int'(d_tuse_rt), rtH, eRt);
    eBusy  = (cyc < busyUntil) ? 1 : 0;
    eStall = (d_valid && !flush && (rsH != 0 || rtH != 0 || (d_isdm && eBusy != 0))) ? 1 : 0;
  endfunction

  function automatic void clearHist();
    for (int k = 1; k <= STG; k++) begin
      hv[k] = 0; hwr[k] = 0; ha3[k] = 0; htn[k] = 0;
    end
  endfunction

  function automatic void updateModel();
    int issued;
    cyc++;
    if (reset) begin
      clearHist();
      busyUntil = 0;
    end else begin
      issued = (d_valid && eStall == 0 && !flush) ? 1 : 0;
      if (issued != 0 && d_md_start) busyUntil = cyc + (d_md_div ? 10 : 5);
      if (flush) begin
        clearHist();
      end else begin
        for (int k = STG; k >= 2; k--) begin
          hv[k] = hv[k-1]; hwr[k] = hwr[k-1]; ha3[k] = ha3[k-1]; htn[k] = htn[k-1];
        end
        hv[1]  = issued;
        hwr[1] = (issued != 0 && d_regwrite && d_A3 != 5'd0) ? 1 : 0;
        ha3[1] = (issued != 0) ? int'(d_A3) : 0;
        htn[1] = (issued != 0) ? int'(d_tnew) : 0;
      end
    end
  endfunction

  task automatic expectLit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    computeModel();
    expectLit("stall", int'(stall), eStall);
    expectLit("fwd_rs_sel", int'(fwd_rs_sel), eRs);
    expectLit("fwd_rt_sel", int'(fwd_rt_sel), eRt);
    expectLit("md_busy", int'(md_busy), eBusy);
  endtask

  task automatic setInst(input int v, input int a1, input int a2, input int urs, input int urt,
                         input int a3, input int rw, input int tn, input int isdm,
                         input int mds, input int mdd);
    d_valid    = v[0];
    d_A1       = 5'(a1);
    d_A2       = 5'(a2);
    d_tuse_rs  = 3'(urs);
    d_tuse_rt  = 3'(urt);
    d_A3       = 5'(a3);
    d_regwrite = rw[0];
    d_tnew     = 3'(tn);
    d_isdm     = isdm[0];
    d_md_start = mds[0];
    d_md_div   = mdd[0];
  endtask

  task automatic applyStimulus();
    #1;
    checkOutput();
  endtask

  task automatic stepEdge();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic idle();
    setInst(0, 0, 0, 6, 6, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int tuseTab [5] = '{0, 1, 2, 3, 6};
    clearHist();
    reset = 1'b1;
    flush = 1'b0;
    idle();
    stepEdge();
    reset = 1'b0;

    // reset state
    applyStimulus();
    expectLit("reset stall", int'(stall), 0);
    expectLit("reset rs_sel", int'(fwd_rs_sel), 0);
    expectLit("reset md_busy", int'(md_busy), 0);
    stepEdge();

    // addu $3 then beq $3,$3
    setInst(1, 1, 2, 1, 1, 3, 1, 2, 0, 0, 0); applyStimulus(); stepEdge();
    setInst(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0); applyStimulus();
    expectLit("beq stall", int'(stall), 1);
    stepEdge(); applyStimulus();
    expectLit("beq stall after", int'(stall), 0);
    expectLit("beq rs_sel", int'(fwd_rs_sel), 2);
    expectLit("beq rt_sel", int'(fwd_rt_sel), 2);
    stepEdge();

    // lw $5 then addu $6,$5,$0
    setInst(1, 29, 0, 1, 6, 5, 1, 3, 0, 0, 0); applyStimulus(); stepEdge();
    setInst(1, 5, 0, 1, 1, 6, 1, 2, 0, 0, 0); applyStimulus();
    expectLit("lw-use stall", int'(stall), 1);
    stepEdge(); applyStimulus();
    expectLit("lw-use stall after", int'(stall), 0);
    expectLit("lw-use rs_sel", int'(fwd_rs_sel), 0);
    stepEdge();

    // lw $5 then sw $5 (rt needed late)
    setInst(1, 29, 0, 1, 6, 5, 1, 3, 0, 0, 0); applyStimulus(); stepEdge();
    setInst(1, 29, 5, 1, 2, 0, 0, 0, 0, 0, 0); applyStimulus();
    expectLit("lw-sw stall", int'(stall), 0);
    stepEdge();

    // two $7 writers, jr $7 must follow the younger one
    setInst(1, 0, 0, 6, 6, 7, 1, 3, 0, 0, 0); applyStimulus(); stepEdge();
    setInst(1, 0, 0, 6, 6, 7, 1, 1, 0, 0, 0); applyStimulus(); stepEdge();
    setInst(1, 7, 0, 0, 6, 0, 0, 0, 0, 0, 0); applyStimulus();
    expectLit("jr stall", int'(stall), 0);
    expectLit("jr rs_sel", int'(fwd_rs_sel), 1);
    stepEdge();

    // $0 writer never creates a hazard
    setInst(1, 0, 0, 6, 6, 0, 1, 2, 0, 0, 0); applyStimulus(); stepEdge();
    setInst(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); applyStimulus();
    expectLit("zero-reg stall", int'(stall), 0);
    expectLit("zero-reg rs_sel", int'(fwd_rs_sel), 0);
    stepEdge();

    // div then mflo, with a flush inside the busy window
    setInst(1, 8, 9, 1, 1, 0, 0, 0, 1, 1, 1); applyStimulus(); stepEdge();
    setInst(1, 0, 0, 6, 6, 10, 1, 2, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      flush = (i == 4);
      applyStimulus();
      expectLit("mflo stall", int'(stall), (i == 4) ? 0 : 1);
      expectLit("mflo md_busy", int'(md_busy), 1);
      stepEdge();
    end
    flush = 1'b0;
    applyStimulus();
    expectLit("mflo release stall", int'(stall), 0);
    expectLit("mflo release busy", int'(md_busy), 0);
    stepEdge();

    // flush with lw $2 in E and a reader in D
    setInst(1, 0, 0, 6, 6, 2, 1, 3, 0, 0, 0); applyStimulus(); stepEdge();
    setInst(1, 2, 0, 1, 6, 4, 1, 2, 0, 0, 0);
    flush = 1'b1;
    applyStimulus();
    expectLit("flush stall", int'(stall), 0);
    stepEdge();
    flush = 1'b0;
    applyStimulus();
    expectLit("post-flush stall", int'(stall), 0);
    expectLit("post-flush rs_sel", int'(fwd_rs_sel), 0);
    stepEdge();

    // reset mid-operation
    setInst(1, 0, 0, 6, 6, 11, 1, 3, 0, 0, 0); applyStimulus(); stepEdge();
    setInst(1, 0, 0, 6, 6, 12, 1, 3, 0, 0, 0); applyStimulus(); stepEdge();
    setInst(1, 0, 0, 6, 6, 13, 1, 3, 0, 0, 0); applyStimulus(); stepEdge();
    setInst(1, 8, 9, 6, 6, 0, 0, 0, 1, 1, 1); applyStimulus(); stepEdge();
    idle();
    reset = 1'b1;
    stepEdge();
    reset = 1'b0;
    setInst(1, 13, 12, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus();
    expectLit("post-reset stall", int'(stall), 0);
    expectLit("post-reset rs_sel", int'(fwd_rs_sel), 0);
    expectLit("post-reset rt_sel", int'(fwd_rt_sel), 0);
    expectLit("post-reset busy", int'(md_busy), 0);
    stepEdge();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int mds;
      mds = ($urandom_range(0, 19) == 0) ? 1 : 0;
      setInst(($urandom_range(0, 99) < 85) ? 1 : 0,
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              tuseTab[$urandom_range(0, 4)], tuseTab[$urandom_range(0, 4)],
              int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 4)),
              (mds != 0 || $urandom_range(0, 9) == 0) ? 1 : 0,
              mds, int'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 32) == 0);
      reset = ($urandom_range(0, 99) == 0);
      applyStimulus();
      stepEdge();
    end
    reset = 1'b0;
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
